// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared FSM states and command-word layout for cmd_dispatcher
package dispatch_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_F_HDR,
        S_F_OPS,
        S_ISSUE,
        S_WAIT_CP,
        S_WB,
        S_DONE,
        S_ERR
    } state_t;
    localparam int OP_LSB        = 0;
    localparam int OP_W          = 3;
    localparam int SIZE_LSB      = 3;
    localparam int SIZE_W        = 2;
    localparam int WORDS_PER_CMD = 2;
endpackage

// File: rtl/lat_counter.sv
// lat_counter: loadable down-counter that reports when it has run out
module lat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: walks a command list in memory, issues each to the coprocessor and writes results back
module cmd_dispatcher
    import dispatch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ELEM_W  = DATA_W / 2,
    parameter int RD_LAT  = 1,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cp_start,
    output logic [2:0]        cp_op,
    output logic [1:0]        cp_size,
    output logic [ELEM_W-1:0] cp_op_a,
    output logic [ELEM_W-1:0] cp_op_b,
    input  logic              cp_ready,
    input  logic [DATA_W-1:0] cp_result,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_idx
);
    localparam int LW = (TIMEOUT > 8) ? $clog2(TIMEOUT) : 3;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_cnt, r_idx, r_err_idx;
    logic [OP_W-1:0]     r_hdr_op, r_op;
    logic [SIZE_W-1:0]   r_hdr_size, r_size;
    logic [ELEM_W-1:0]   r_op_a, r_op_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_done, r_error;
    logic                w_idle, w_accept, w_zero, w_load, w_last;
    logic [LW-1:0]       w_load_val;
    logic [ADDR_W-1:0]   w_cmd_addr, w_res_addr;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_accept   = w_idle && start;
    assign w_last     = (r_idx + CNT_W'(1)) == r_cnt;
    assign w_cmd_addr = r_base + ADDR_W'(r_idx) * ADDR_W'(WORDS_PER_CMD);
    assign w_res_addr = r_base + ADDR_W'(r_cnt) * ADDR_W'(WORDS_PER_CMD) + ADDR_W'(r_idx);

    // One counter serves both the read-latency wait and the coprocessor timeout
    assign w_load     = ((w_next != r_state) && (w_next == S_F_HDR || w_next == S_F_OPS)) || (r_state == S_ISSUE);
    assign w_load_val = (r_state == S_ISSUE) ? LW'(TIMEOUT - 1) : LW'(RD_LAT);

    lat_counter #(.W(LW)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = (cmd_count == '0) ? S_DONE : S_F_HDR;
            S_F_HDR:   if (w_zero) w_next = S_F_OPS;
            S_F_OPS:   if (w_zero) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT_CP;
            S_WAIT_CP: w_next = cp_ready ? S_WB : (w_zero ? S_ERR : S_WAIT_CP);
            S_WB:      w_next = w_last ? S_DONE : S_F_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_err_idx  <= '0;
            r_hdr_op   <= '0;
            r_hdr_size <= '0;
            r_op       <= '0;
            r_size     <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_accept && cmd_count == '0) || (r_state == S_WB && w_last);
            if (w_accept) begin
                r_base  <= base_addr;
                r_cnt   <= cmd_count;
                r_idx   <= '0;
                r_error <= 1'b0;
            end
            if (r_state == S_F_HDR && w_zero) begin
                r_hdr_op   <= mem_rdata[OP_LSB +: OP_W];
                r_hdr_size <= mem_rdata[SIZE_LSB +: SIZE_W];
            end
            // Issue registers change only on entry to ISSUE so the coprocessor sees stable operands
            if (r_state == S_F_OPS && w_zero) begin
                r_op   <= r_hdr_op;
                r_size <= r_hdr_size;
                r_op_a <= mem_rdata[ELEM_W-1:0];
                r_op_b <= mem_rdata[DATA_W-1:ELEM_W];
            end
            if (r_state == S_WAIT_CP && cp_ready) r_result <= cp_result;
            if (r_state == S_WAIT_CP && !cp_ready && w_zero) begin
                r_error   <= 1'b1;
                r_err_idx <= r_idx;
            end
            if (r_state == S_WB) r_idx <= r_idx + CNT_W'(1);
        end
    end

    assign mem_addr  = (r_state == S_F_HDR) ? w_cmd_addr :
                       (r_state == S_F_OPS) ? w_cmd_addr + ADDR_W'(1) :
                       (r_state == S_WB)    ? w_res_addr : '0;
    assign mem_we    = (r_state == S_WB) && rst;
    assign mem_wdata = r_result;
    assign cp_start  = (r_state == S_ISSUE);
    assign cp_op     = r_op;
    assign cp_size   = r_size;
    assign cp_op_a   = r_op_a;
    assign cp_op_b   = r_op_b;
    assign busy      = !w_idle;
    assign done      = r_done;
    assign error     = r_error;
    assign err_idx   = r_err_idx;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed checks of cmd_dispatcher with a 3-cycle memory and a scripted coprocessor
module tb_cmd_dispatcher;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  base_addr;
    logic [5:0]  cmd_count;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata, mem_wdata;
    logic        mem_we, cp_start;
    logic [2:0]  cp_op;
    logic [1:0]  cp_size;
    logic [7:0]  cp_op_a, cp_op_b;
    logic        cp_ready = 1'b0;
    logic [15:0] cp_result = '0;
    logic        busy, done, error;
    logic [5:0]  err_idx;

    always #5 clk = ~clk;

    cmd_dispatcher #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .CNT_W(6), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .cmd_count(cmd_count),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cp_start(cp_start), .cp_op(cp_op), .cp_size(cp_size), .cp_op_a(cp_op_a), .cp_op_b(cp_op_b),
        .cp_ready(cp_ready), .cp_result(cp_result), .busy(busy), .done(done), .error(error),
        .err_idx(err_idx)
    );

    logic [15:0] mem [256];
    logic [15:0] pipe [3];
    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign mem_rdata = pipe[2];

    // Coprocessor answers 3 cycles after cp_start, never for op 7
    int          cd = 0;
    logic        use_fixed;
    logic [15:0] fixed_res;
    always @(negedge clk) begin
        cp_ready = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                cp_ready  = 1'b1;
                cp_result = use_fixed ? fixed_res : ({cp_op_a, cp_op_b} ^ {13'd0, cp_op});
            end
        end
        if (cp_start && cp_op != 3'd7) cd = 3;
    end

    int          n_start = 0, n_done = 0;
    logic [7:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    logic [2:0]  iss_op [$];
    logic [1:0]  iss_size [$];
    logic [7:0]  iss_a [$], iss_b [$];
    always @(negedge clk) begin
        if (cp_start) begin
            n_start++;
            iss_op.push_back(cp_op);
            iss_size.push_back(cp_size);
            iss_a.push_back(cp_op_a);
            iss_b.push_back(cp_op_b);
        end
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (done) n_done++;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [5:0] c);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        cmd_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_cp(input logic [2:0] op);
        int i;
        i = 0;
        while (!(cp_start && cp_op == op) && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("cp_start_seen", 32'(i < 100), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {busy, done, error, mem_we, cp_start}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_ops"}, {cp_op, cp_size, cp_op_a, cp_op_b}, 0);
        chk({tag, "_wdata_eidx"}, {mem_wdata, err_idx}, 0);
    endtask

    initial begin
        int cyc, s0, w0, d0, i0;
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        cmd_count = '0;
        use_fixed = 1'b0;
        fixed_res = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'hBEEF;
        mem[8'h20] = 16'h0007; mem[8'h21] = 16'h1122;
        mem[8'hFC] = 16'h0019; mem[8'hFD] = 16'h3344;
        mem[8'hFE] = 16'hFFE2; mem[8'hFF] = 16'h5566;
        mem[8'h00] = 16'h000B; mem[8'h01] = 16'h7788;
        mem[8'h50] = 16'h0004; mem[8'h51] = 16'h0102;
        mem[8'h52] = 16'h0007; mem[8'h53] = 16'h0304;
        repeat (3) @(negedge clk);
        chk_zero("por");
        rst = 1'b1;

        // Reset in the middle of WAIT_CP
        w0 = wr_addr.size();
        do_start(8'h20, 6'd1);
        wait_cp(3'd7);
        repeat (2) @(negedge clk);
        chk("mr_busy_before", busy, 1);
        chk("mr_opa_before", cp_op_a, 8'h22);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("mr");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_no_write", wr_addr.size() - w0, 0);
        chk("mr_idle", busy, 0);

        // Single command
        use_fixed = 1'b1;
        fixed_res = 16'h1234;
        s0 = n_start; w0 = wr_addr.size(); d0 = n_done; i0 = iss_a.size();
        do_start(8'h10, 6'd1);
        chk("s1_hdr_addr", mem_addr, 8'h10);
        chk("s1_busy", busy, 1);
        wait_done(cyc);
        chk("s1_latency", cyc, 13);
        chk("s1_done", done, 1);
        chk("s1_busy_fall", busy, 0);
        repeat (2) @(negedge clk);
        chk("s1_done_once", n_done - d0, 1);
        chk("s1_starts", n_start - s0, 1);
        chk("s1_writes", wr_addr.size() - w0, 1);
        chk("s1_waddr", wr_addr[w0], 8'h12);
        chk("s1_wdata", wr_data[w0], 16'h1234);
        chk("s1_op", iss_op[i0], 5);
        chk("s1_size", iss_size[i0], 0);
        chk("s1_op_a", iss_a[i0], 8'hEF);
        chk("s1_op_b", iss_b[i0], 8'hBE);
        chk("s1_op_a_held", cp_op_a, 8'hEF);

        // Three commands wrapping past 0xFF, with a start pulse during WAIT_CP
        use_fixed = 1'b0;
        s0 = n_start; w0 = wr_addr.size(); d0 = n_done; i0 = iss_a.size();
        do_start(8'hFC, 6'd3);
        wait_cp(3'd1);
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h40;
        cmd_count = 6'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("m_done", done, 1);
        repeat (2) @(negedge clk);
        chk("m_starts", n_start - s0, 3);
        chk("m_done_once", n_done - d0, 1);
        chk("m_writes", wr_addr.size() - w0, 3);
        chk("m_waddr0", wr_addr[w0], 8'h02);
        chk("m_waddr1", wr_addr[w0 + 1], 8'h03);
        chk("m_waddr2", wr_addr[w0 + 2], 8'h04);
        chk("m_wdata0", wr_data[w0], 16'h4432);
        chk("m_wdata1", wr_data[w0 + 1], 16'h6657);
        chk("m_wdata2", wr_data[w0 + 2], 16'h8874);
        chk("m_ops", {iss_op[i0], iss_op[i0 + 1], iss_op[i0 + 2]}, {3'd1, 3'd2, 3'd3});
        chk("m_sizes", {iss_size[i0], iss_size[i0 + 1], iss_size[i0 + 2]}, {2'd3, 2'd0, 2'd1});
        chk("m_op_a2", iss_a[i0 + 2], 8'h88);

        // Zero-length list
        s0 = n_start; w0 = wr_addr.size(); d0 = n_done;
        do_start(8'h30, 6'd0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        chk("z_starts", n_start - s0, 0);
        chk("z_writes", wr_addr.size() - w0, 0);
        chk("z_done_once", n_done - d0, 1);

        // Timeout on command 1 of 2
        s0 = n_start; w0 = wr_addr.size(); d0 = n_done;
        do_start(8'h50, 6'd2);
        wait_cp(3'd7);
        cyc = 0;
        while (!error && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t_cycles", cyc, 9);
        chk("t_err_idx", err_idx, 1);
        chk("t_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t_err_held", error, 1);
        chk("t_writes", wr_addr.size() - w0, 1);
        chk("t_waddr", wr_addr[w0], 8'h54);
        chk("t_wdata", wr_data[w0], 16'h0205);
        chk("t_no_done", n_done - d0, 0);
        do_start(8'h30, 6'd0);
        chk("t_err_clear", error, 0);
        chk("t_restart_done", done, 1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Parametrised successor to the single-shot memory-to-coprocessor input interface.
- Walks a command list held in the on-chip memory starting at base_addr. Each command is decoded into op/size/operands and issued to control_unit with a start/ready handshake. The result is written back to memory.
- Adds a configurable command count, memory read latency, result write-back and a coprocessor timeout.
- Sits between the memory instance and control_unit.

Parameters:
- ADDR_W, 8: memory address width.
- DATA_W, 16: memory word width. Must be even.
- ELEM_W, DATA_W/2: operand width. Each operand is half a word.
- RD_LAT, 1: memory read latency in cycles, from mem_addr valid to mem_rdata valid. Legal range 1..4.
- CNT_W, 6: width of cmd_count.
- TIMEOUT, 255: maximum cycles to wait for cp_ready.

Ports:
- clk in 1: system clock. All logic is on its rising edge.
- rst in 1: reset. Synchronous, active-low.
- start in 1: launch pulse. Sampled only in IDLE/DONE/ERR.
- base_addr in ADDR_W: address of the first command word. Sampled at accepted start.
- cmd_count in CNT_W: number of commands. Sampled at accepted start.
- mem_addr out ADDR_W: memory address.
- mem_rdata in DATA_W: memory read data.
- mem_wdata out DATA_W: write-back data.
- mem_we out 1: write enable, one cycle.
- cp_start out 1: coprocessor start pulse.
- cp_op out 3: operation code.
- cp_size out 2: matrix size code.
- cp_op_a out ELEM_W: operand1.
- cp_op_b out ELEM_W: operand2.
- cp_ready in 1: coprocessor completion.
- cp_result in DATA_W: coprocessor result. Valid while cp_ready is high.
- busy out 1: high in any state other than IDLE/DONE/ERR.
- done out 1: one-cycle pulse when the list completes.
- error out 1: timeout flag. Held until the next accepted start or reset.
- err_idx out CNT_W: index of the command that timed out.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including mem_addr, mem_we, cp_start, cp_op/size/op_a/op_b, busy, done, error, err_idx.
  - Reset mid-operation abandons the list. No write is issued in the reset cycle.
- Command format, 2 consecutive words per command:
  - Header word: bits [2:0] = op, bits [4:3] = size. Remaining bits are ignored.
  - Operand word: bits [ELEM_W-1:0] = op_a, bits [DATA_W-1:ELEM_W] = op_b.
- Addressing:
  - Command i is at base + 2i and base + 2i + 1.
  - The result for command i goes to base + 2*cmd_count + i.
  - All addresses wrap modulo 2^ADDR_W.
- State machine:
  - IDLE/DONE/ERR: on start=1, latch base_addr and cmd_count, clear error, set idx=0. If cmd_count=0, go to DONE and pulse done the next cycle. Otherwise go to F_HDR.
  - F_HDR: drive mem_addr = header address. Wait RD_LAT cycles (latency counter), then capture op/size into registers and go to F_OPS.
  - F_OPS: same as F_HDR for the operand address. Capture op_a/op_b, then go to ISSUE.
  - ISSUE: cp_start=1 for exactly one cycle. cp_op/size/op_a/op_b stay stable from this cycle until the next ISSUE. Go to WAIT_CP with the timeout counter at 0.
  - WAIT_CP: cp_ready is ignored in the ISSUE cycle and sampled from the following cycle.
    - On cp_ready=1: latch cp_result and go to WB.
    - If the counter reaches TIMEOUT without cp_ready: set error=1, err_idx=idx, go to ERR. No write-back.
  - WB: mem_we=1 for one cycle, with mem_addr = result address and mem_wdata = latched result. Then idx+1. If idx+1 = cmd_count, go to DONE with done=1 for that one cycle. Otherwise go to F_HDR.
  - DONE and ERR are idle states that behave like IDLE.
- Per-command latency: 2*(RD_LAT+1) + 1 + k + 1 cycles, where k = cycles from cp_start to cp_ready (k ≥ 1).
- A start pulse while busy is ignored.
- mem_we is 0 in all states other than WB.

Decomposition:
- Shared package dispatch_pkg:
  - state enum localparams.
  - header field offsets: OP_LSB=0, OP_W=3, SIZE_LSB=3, SIZE_W=2.
  - WORDS_PER_CMD=2.
- One natural sub-module: lat_counter, a reusable down-counter shared by the RD_LAT wait and the timeout.

Test Plan:
- Reset: rst=0 for 2 cycles mid-WAIT_CP → all outputs 0 and state IDLE. A later start with base=0x10, count=1 runs cleanly.
- Single command: mem[0x10]=0x0005 (op=5, size=0), mem[0x11]=0xBEEF, start with count=1; cp_ready 3 cycles after cp_start with result 0x1234 → cp_op_a=0xEF, cp_op_b=0xBE, mem[0x12]=0x1234, done pulses once, busy falls.
- Multi-command and wrap: base=0xFC, count=3 → headers read at 0xFC, 0xFE, 0x00. Results written at 0x02, 0x03, 0x04. Exactly 3 cp_start pulses.
- Zero count: start with count=0 → no memory access, no cp_start, done pulses within 2 cycles.
- Timeout: TIMEOUT=8, cp_ready held 0 on command 1 of 2 → error=1 and err_idx=1 after 8 wait cycles. No mem_we for command 1. Error clears on the next start.
- Latency and ignored start: RD_LAT=3 → operands are captured 3 cycles after each address. A start pulse during WAIT_CP has no effect.
